// File: rtl/pipe_share_arbiter.sv
// rtl/pipe_share_arbiter.sv - round-robin sharing of one fixed-latency stallable pipeline
module pipe_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 3,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = $clog2(LAT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [WIDTH-1:0]            pipe_in,
    output logic                        pipe_stall,
    input  logic [WIDTH-1:0]            pipe_out,
    output logic                        rsp_valid,
    output logic [IDW-1:0]              rsp_id,
    output logic [WIDTH-1:0]            rsp_data,
    input  logic                        rsp_ready,
    input  logic                        flush,
    output logic                        idle,
    output logic [CNTW-1:0]             occupancy
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

    state_t                   state_q, state_d;
    logic                     idle_q, idle_d;
    logic [LAT-1:0]           sv_q, sv_d;
    logic [LAT-1:0][IDW-1:0]  sid_q, sid_d;
    logic [IDW-1:0]           ptr_q, ptr_d;
    logic [CNTW-1:0]          occ_q, occ_d;
    logic [IDW-1:0]           winner;
    logic                     grant_en, issue, rsp_fire;

    assign rsp_valid  = sv_q[LAT-1];
    assign rsp_id     = sid_q[LAT-1];
    assign rsp_data   = pipe_out;
    assign pipe_stall = rsp_valid & ~rsp_ready;
    assign idle       = idle_q;
    assign occupancy  = occ_q;

    // Grants are held off while reset is asserted, since reset is asynchronous.
    assign grant_en = rst & (state_q == ST_RUN) & ~flush & ~pipe_stall;
    assign issue    = grant_en & (|req_valid);
    assign rsp_fire = rsp_valid & rsp_ready;

    always_comb begin : p_winner
        int idx;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) winner = IDW'(idx);
        end
    end

    always_comb begin
        req_ready = '0;
        pipe_in   = '0;
        if (issue) begin
            req_ready[winner] = 1'b1;
            pipe_in           = req_data[winner];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    end

    always_comb begin
        sv_d  = sv_q;
        sid_d = sid_q;
        if (!pipe_stall) begin
            sv_d[0]  = issue;
            sid_d[0] = winner;
            for (int k = 1; k < LAT; k++) begin
                sv_d[k]  = sv_q[k-1];
                sid_d[k] = sid_q[k-1];
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({issue, rsp_fire})
            2'b10:   occ_d = occ_q + CNTW'(1);
            2'b01:   occ_d = occ_q - CNTW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (occ_q == '0) state_d = ST_IDLE;
            ST_IDLE:  if (!flush) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            idle_q  <= 1'b0;
            sv_q    <= '0;
            sid_q   <= '0;
            ptr_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            sv_q    <= sv_d;
            sid_q   <= sid_d;
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// tb/tb_pipe_share_arbiter.sv - randomized check of pipe_share_arbiter against a transaction model
module tb_pipe_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 3;
    localparam int IDW   = 2;
    localparam int CNTW  = 2;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [NREQ-1:0]             req_valid = '0;
    logic [NREQ-1:0][WIDTH-1:0]  req_data = '0;
    logic [NREQ-1:0]             req_ready;
    logic [WIDTH-1:0]            pipe_in;
    logic                        pipe_stall;
    logic [WIDTH-1:0]            pipe_out;
    logic                        rsp_valid;
    logic [IDW-1:0]              rsp_id;
    logic [WIDTH-1:0]            rsp_data;
    logic                        rsp_ready = 1'b1;
    logic                        flush = 1'b0;
    logic                        idle;
    logic [CNTW-1:0]             occupancy;

    int errors = 0;
    int checks = 0;

    pipe_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pipe_in(pipe_in), .pipe_stall(pipe_stall), .pipe_out(pipe_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .flush(flush), .idle(idle), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Shared compute pipeline: x*3+1 in the first stage, pure delay after.
    logic [WIDTH-1:0] st [LAT];
    always @(posedge clk) begin
        if (!pipe_stall) begin
            st[0] <= pipe_in * 3 + 1;
            for (int k = 1; k < LAT; k++) st[k] <= st[k-1];
        end
    end
    assign pipe_out = st[LAT-1];

    typedef struct {
        int               id;
        logic [WIDTH-1:0] res;
        int               age;
    } ent_t;

    ent_t q[$];
    int   m_ptr  = 0;
    int   m_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [NREQ-1:0] rv, input logic rr, input logic fl, input logic rs);
        logic             exp_rv, exp_stall, grant, iss;
        logic [NREQ-1:0]  exp_ready;
        logic [WIDTH-1:0] exp_pin;
        int               w, occ_before;
        @(negedge clk);
        req_valid = rv;
        rsp_ready = rr;
        flush     = fl;
        rst       = rs;
        for (int i = 0; i < NREQ; i++) req_data[i] = $urandom;
        #1;
        if (!rs) begin
            q.delete();
            m_ptr  = 0;
            m_mode = 0;
        end
        exp_rv    = (q.size() > 0) && (q[0].age == LAT - 1);
        exp_stall = exp_rv && !rr;
        grant     = rs && (m_mode == 0) && !fl && !exp_stall;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && rv[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        iss       = grant && (w >= 0);
        exp_ready = '0;
        exp_pin   = '0;
        if (iss) begin
            exp_ready[w] = 1'b1;
            exp_pin      = req_data[w];
        end
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("pipe_stall", 64'(pipe_stall), 64'(exp_stall));
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("pipe_in", 64'(pipe_in), 64'(exp_pin));
        check("idle", 64'(idle), 64'(m_mode == 2));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        if (exp_rv) begin
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_data", 64'(rsp_data), 64'(q[0].res));
        end
        if (!rs) check("rsp_id_rst", 64'(rsp_id), 64'd0);
        if (rs) begin
            occ_before = q.size();
            if (!exp_stall) begin
                if (exp_rv) void'(q.pop_front());
                foreach (q[j]) q[j].age++;
                if (iss) begin
                    q.push_back('{w, req_data[w] * 3 + 1, 0});
                    m_ptr = (w + 1) % NREQ;
                end
            end
            case (m_mode)
                0: if (fl) m_mode = 1;
                1: if (occ_before == 0) m_mode = 2;
                default: if (!fl) m_mode = 0;
            endcase
        end
    endtask

    initial begin
        repeat (2) cyc(4'hF, 1'b1, 1'b0, 1'b0);
        cyc(4'h0, 1'b1, 1'b0, 1'b1);
        cyc(4'b0100, 1'b1, 1'b0, 1'b1);
        repeat (5) cyc(4'h0, 1'b1, 1'b0, 1'b1);
        repeat (8) cyc(4'hF, 1'b1, 1'b0, 1'b1);
        repeat (4) cyc(4'h0, 1'b1, 1'b0, 1'b1);
        repeat (4) cyc(4'hF, 1'b1, 1'b0, 1'b1);
        repeat (5) cyc(4'hF, 1'b0, 1'b0, 1'b1);
        repeat (6) cyc(4'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc(4'hF, 1'b0, 1'b0, 1'b1);
        cyc(4'hF, 1'b1, 1'b1, 1'b1);
        repeat (6) cyc(4'hF, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(4'hF, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(4'hF, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(4'hF, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            cyc(NREQ'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 299) != 0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_share_arbiter.md
# pipe_share_arbiter

Round-robin arbiter and sequencer that shares one fixed-latency, stallable datapath pipeline (a chain of delay/compute stages with a common stall input) among NREQ requesters. It grants at most one request per cycle into the pipeline and tracks valid and requester-ID through a shadow pipeline of the same depth. It drives the pipeline stall from downstream back-pressure and returns each result tagged with its originator. A flush/drain FSM lets control logic quiesce the shared unit before reconfiguration.

## Interface
Parameters:
- NREQ, 4, number of requesters (>=2)
- WIDTH, 32, request/result data width
- LAT, 3, shared-pipeline latency in cycles (>=1); must equal the DELAY of the controlled pipeline
- IDW, $clog2(NREQ), requester-ID width (derived)
- CNTW, $clog2(LAT+1), occupancy counter width (derived)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ x WIDTH  per-requester operand
- req_ready  out  NREQ  one-hot-or-zero grant/accept
- pipe_in  out  WIDTH  operand into shared pipeline
- pipe_stall  out  1  stall to every pipeline stage
- pipe_out  in  WIDTH  result from last pipeline stage
- rsp_valid  out  1  result valid
- rsp_id  out  IDW  originating requester index
- rsp_data  out  WIDTH  result (= pipe_out)
- rsp_ready  in  1  downstream accepts result
- flush  in  1  request quiesce
- idle  out  1  pipeline empty and FSM in IDLE
- occupancy  out  CNTW  in-flight request count

## Operation
- Shadow pipeline: sv[0..LAT-1] valid bits, sid[0..LAT-1] IDs. When pipe_stall=0: sv[0]<=issue, sid[0]<=winner, sv[k]<=sv[k-1], sid[k]<=sid[k-1]. When pipe_stall=1: all hold.
- rsp_valid = sv[LAT-1]; rsp_id = sid[LAT-1]; rsp_data = pipe_out (combinational pass-through).
- pipe_stall = sv[LAT-1] & ~rsp_ready. No stall when tail empty, even if rsp_ready=0.
- Arbitration: grant_en = (state==RUN) & ~flush & ~pipe_stall. Winner = first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ. req_ready[winner]=grant_en; all others 0. issue = grant_en & |req_valid.
- pipe_in = req_data[winner] when issue, else 0.
- ptr: reset 0; on issue ptr <= (winner+1) mod NREQ; else holds.
- req_ready depends combinationally on req_valid; requesters must not derive req_valid from req_ready.
- occupancy: +1 on issue, -1 on rsp_valid&rsp_ready, unchanged if both or neither. Never exceeds LAT.
- FSM states RUN, DRAIN, IDLE:
  - RUN: flush=1 -> DRAIN (no grant in that cycle, already gated by ~flush).
  - DRAIN: no grants; occupancy==0 -> IDLE, regardless of flush.
  - IDLE: idle=1, no grants; flush=0 -> RUN.
- Shared pipeline data contents are don't-care while sv is 0; its reset is driven separately.

## Timing
- Reset (rst=0, asynchronous): sv=0, sid=0, ptr=0, occupancy=0, state=RUN. Outputs: req_ready=0 (held off while rst asserted), rsp_valid=0, rsp_id=0, pipe_stall=0, pipe_in=0, idle=0.
- Reset mid-operation: all in-flight entries discarded, no responses emitted.
- Latency: request accepted at edge t with no stalls -> rsp_valid=1 in cycle t+LAT. Each pipe_stall cycle adds one cycle.
- Throughput: one issue per cycle while rsp_ready=1.
- Stall cycle: no issue, shadow and pipeline hold, rsp outputs stable.
- Simultaneous flush and request in RUN: request not accepted.
- DRAIN->IDLE: idle asserts the cycle after occupancy reaches 0. IDLE->RUN: grants resume the cycle after flush deasserts.

## Test plan
- Single requester 2 sends data 0x11 at t0, rsp_ready=1, LAT=3 -> rsp_valid at t0+3 with rsp_id=2, rsp_data=pipe_out; occupancy 1 for 3 cycles, then 0.
- All 4 req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_ids emerge in the same order, back-to-back.
- Full pipe, then rsp_ready=0 for 5 cycles -> pipe_stall=1 for 5 cycles, req_ready all 0, rsp_id/rsp_data stable; order resumes intact with no loss or duplicate.
- 3 in flight, then flush pulsed 1 cycle -> no further grants, DRAIN until 3 responses taken, idle=1, then RUN and grants resume next cycle.
- rst deasserted-to-asserted with 2 entries in flight -> rsp_valid=0 immediately, occupancy=0, ptr=0; after release, requester 0 wins first when all request.
- rsp handshake and new issue in the same cycle at occupancy 2 -> occupancy stays 2.
